// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the HI/LO multiply/divide resource.
// Holds the 5-bit ALU control codes (same values the ALU control decode
// drives), the FSM state encoding, the iteration count, and small op
// classification helpers used by the sequencer.
package muldiv_sequencer_pkg;

  localparam logic [4:0] OPMULT  = 5'b01000;
  localparam logic [4:0] OPMULTU = 5'b01001;
  localparam logic [4:0] OPDIV   = 5'b01010;
  localparam logic [4:0] OPDIVU  = 5'b01011;
  localparam logic [4:0] OPMTHI  = 5'b01100;
  localparam logic [4:0] OPMTLO  = 5'b01101;
  localparam logic [4:0] OPMFHI  = 5'b01110;
  localparam logic [4:0] OPMFLO  = 5'b01111;

  localparam int ITERATIONS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return (op == OPMULT) || (op == OPMULTU) || (op == OPDIV) || (op == OPDIVU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OPDIV) || (op == OPDIVU);
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OPMULT) || (op == OPDIV);
  endfunction

  // Any opcode that touches HI/LO; these must wait while an op is in flight.
  function automatic logic is_hilo_op(input logic [4:0] op);
    return is_muldiv_op(op) || (op == OPMTHI) || (op == OPMTLO) ||
           (op == OPMFHI) || (op == OPMFLO);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Iterative multiply/divide datapath.
// Ports:
//   iCLK, iRST         clock, synchronous active-high reset
//   load               latch operand magnitudes and sign flags from a/b
//   step               perform one shift-add or restoring-divide iteration
//   is_signed, is_div  op class, sampled with load
//   a, b               raw operands (multiplicand/dividend, multiplier/divisor)
//   res_hi, res_lo     sign-corrected result (HI: product high / remainder,
//                      LO: product low / quotient), valid after the last step
module muldiv_datapath #(
  parameter int W = 32
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         load,
  input  logic         step,
  input  logic         is_signed,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo
);

  // p_q: upper half is the accumulator/remainder, lower half starts as the
  // multiplier/dividend and fills with product/quotient bits.
  logic [2*W-1:0] p_q, p_d;
  logic [W-1:0]   d_q, d_d;
  logic           div_q, div_d;
  logic           neg_q, neg_d;
  logic           rneg_q, rneg_d;

  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     rem_top;
  logic [W+1:0]   div_diff;
  logic [2*W-1:0] prod_fixed;
  logic [W-1:0]   quo_fixed, rem_fixed;
  logic           unused_div_msb;

  always_comb begin
    a_mag    = (is_signed && a[W-1]) ? -a : a;
    b_mag    = (is_signed && b[W-1]) ? -b : b;
    mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, d_q} : {(W+1){1'b0}});
    rem_top  = p_q[2*W-1:W-1];
    // Bit W+1 is the borrow; when there is none the difference is below the
    // divisor, so bit W is always zero and only W bits are kept.
    div_diff = {1'b0, rem_top} - {2'b00, d_q};
    unused_div_msb = div_diff[W];

    p_d    = p_q;
    d_d    = d_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;

    if (load) begin
      p_d    = {{W{1'b0}}, a_mag};
      d_d    = b_mag;
      div_d  = is_div;
      neg_d  = is_signed & (a[W-1] ^ b[W-1]);
      rneg_d = is_signed & a[W-1];
    end else if (step) begin
      if (div_q) begin
        if (!div_diff[W+1]) begin
          p_d = {div_diff[W-1:0], p_q[W-2:0], 1'b1};
        end else begin
          p_d = {p_q[2*W-2:0], 1'b0};
        end
      end else begin
        p_d = {mul_sum, p_q[W-1:1]};
      end
    end

    prod_fixed = neg_q  ? -p_q          : p_q;
    quo_fixed  = neg_q  ? -p_q[W-1:0]   : p_q[W-1:0];
    rem_fixed  = rneg_q ? -p_q[2*W-1:W] : p_q[2*W-1:W];
    res_hi     = div_q ? rem_fixed : prod_fixed[2*W-1:W];
    res_lo     = div_q ? quo_fixed : prod_fixed[W-1:0];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      p_q    <= '0;
      d_q    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      d_q    <= d_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide sequencer: FSM, iteration counter, stall logic and
// the architectural HI/LO registers.
// Ports:
//   iCLK, iRST   clock, synchronous active-high reset
//   iStart, iOp  issue strobe and 5-bit ALU control code
//   iA, iB       rs / rt operands
//   oHI, oLO     HI/LO registers
//   oBusy        mult/div in flight (ITER, FIX)
//   oStall       combinational: HI/LO issue must be held while busy
//   oDone        one-cycle pulse after a mult/div result lands in HI/LO
//   oDivByZero   pulse with oDone when the divisor was zero
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an issue; MTHI/MTLO write here
// ITER  | one multiply/divide iteration per edge, 32 edges
// FIX   | sign correction, HI/LO written at this edge
// DONE  | oDone pulse; accepts a new issue exactly like IDLE
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iStart,
  input  logic [4:0]            iOp,
  input  logic [DATA_WIDTH-1:0] iA,
  input  logic [DATA_WIDTH-1:0] iB,
  output logic [DATA_WIDTH-1:0] oHI,
  output logic [DATA_WIDTH-1:0] oLO,
  output logic                  oBusy,
  output logic                  oStall,
  output logic                  oDone,
  output logic                  oDivByZero
);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  div0_q, div0_d;

  logic                  dp_load, dp_step;
  logic [DATA_WIDTH-1:0] dp_hi, dp_lo;

  muldiv_datapath #(.W(DATA_WIDTH)) u_datapath (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .load      (dp_load),
    .step      (dp_step),
    .is_signed (is_signed_op(iOp)),
    .is_div    (is_div_op(iOp)),
    .a         (iA),
    .b         (iB),
    .res_hi    (dp_hi),
    .res_lo    (dp_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div0_d  = div0_q;
    dp_load = 1'b0;
    dp_step = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        div0_d  = 1'b0;
        if (iStart) begin
          if (is_muldiv_op(iOp)) begin
            if (is_div_op(iOp) && (iB == '0)) begin
              // Divide by zero bypasses the iterations entirely.
              lo_d    = '1;
              hi_d    = iA;
              div0_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              dp_load = 1'b1;
              cnt_d   = '0;
              state_d = ST_ITER;
            end
          end else if (iOp == OPMTHI) begin
            hi_d = iA;
          end else if (iOp == OPMTLO) begin
            lo_d = iA;
          end
        end
      end
      ST_ITER: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == CNT_WIDTH'(ITERATIONS - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        hi_d    = dp_hi;
        lo_d    = dp_lo;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  assign oHI        = hi_q;
  assign oLO        = lo_q;
  assign oBusy      = (state_q == ST_ITER) || (state_q == ST_FIX);
  assign oStall     = iStart && oBusy && is_hilo_op(iOp);
  assign oDone      = (state_q == ST_DONE);
  assign oDivByZero = (state_q == ST_DONE) && div0_q;

endmodule
